qconv2d_out_stream: RTL
=======================

Name: qconv2d_out_stream

Overview:
- Output stage placed directly downstream of the combinational qconv2d array.
- Captures the full parallel accumulator vector y (YN words of YB bits) in one handshake.
- Requantizes each word: rounding right-shift, ReLU, saturation to OB bits.
- Streams the results LANES words per beat over a valid/ready interface, so they can feed the next layer's input loader or a DMA.

Parameters:
- YN, 128, number of accumulator words per frame; must be a multiple of LANES.
- YB, 21, accumulator width (XB+KB+$clog2(3*3*1+1) = 11+6+4), two's complement.
- OB, 11, output word width (matches next layer XB), two's complement.
- LANES, 4, output words per beat; BEATS = YN/LANES.
- SHIFT, 6, requantization right-shift amount, 0..YB-1.

Ports:
- clk, in, 1, single clock, rising edge.
- rstn, in, 1, synchronous active-low reset.
- s_valid, in, 1, upstream frame valid.
- s_ready, out, 1, block can accept a frame.
- s_y, in, YN*YB, packed accumulators; word n at bits [n*YB +: YB].
- m_valid, out, 1, output beat valid.
- m_ready, in, 1, downstream accepts beat.
- m_data, out, LANES*OB, lane j at bits [j*OB +: OB].
- m_last, out, 1, marks final beat of frame.
- busy, out, 1, frame held or streaming.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rstn), sampled on the rising edge of clk.
- Reset (rstn=0 at an edge):
  - state=IDLE, beat index idx=0, m_valid=0, m_last=0, busy=0.
  - Captured frame register is not cleared (don't-care).
  - s_ready is forced 0 while rstn=0.
- States: IDLE and STREAM.
- IDLE:
  - s_ready=1, m_valid=0.
  - On s_valid&s_ready: register s_y, set idx=0, go to STREAM.
- STREAM:
  - s_ready=0, busy=1, m_valid=1.
  - m_data = requant of words idx*LANES+j, j=0..LANES-1.
  - m_last=1 when idx==BEATS-1.
  - On m_valid&m_ready: if idx==BEATS-1, go to IDLE and set idx=0; else idx++.
- Latency and cadence:
  - Frame accepted at edge N; first beat is valid in the cycle after edge N.
  - With m_ready held at 1, a frame takes BEATS cycles in STREAM plus 1 IDLE cycle, giving a minimum cadence of BEATS+1 cycles.
- Backpressure:
  - While m_valid=1 and m_ready=0, m_data, m_last and idx hold stable.
  - m_valid never drops mid-frame.
  - s_y is ignored outside IDLE.
- Requant per word (m_data is combinational from the frame register and idx):
  - t = sign-extend(y) to YB+1 bits.
  - If SHIFT>0: t += 1<<(SHIFT-1), giving round-half-up.
  - r = t >>> SHIFT (arithmetic shift).
  - ReLU: r<0 gives 0.
  - Saturate: r > 2^(OB-1)-1 gives 2^(OB-1)-1.
  - Output is the low OB bits.
  - The YB+1 intermediate width prevents overflow on the rounding add.
- Simultaneous events:
  - Reset has priority over every handshake.
  - A reset mid-frame discards the rest of the frame; no m_last is emitted.
  - s_ready is 1 in the cycle after rstn returns to 1.

Optional Feature:
- Macro: QOUT_RELU_EN.
- Defined: ReLU applied as above; outputs lie in [0, 2^(OB-1)-1].
- Undefined: no ReLU; signed saturation to [-2^(OB-1), 2^(OB-1)-1]. With OB=11 the range is [-1024, 1023].
- All other behaviour is identical.

Test Plan:
- Rounding (defaults, QOUT_RELU_EN defined):
  - Stimulus: words 0..3 = 100, 95, 96, 31; m_ready=1.
  - Required: beat 0 lanes = 2, 1, 2, 0.
  - Required: m_valid appears the cycle after the accept; m_last only on beat 31.
- ReLU and saturation:
  - Stimulus: words = -100, 200000, 1048575, -1048576.
  - With QOUT_RELU_EN: 0, 1023, 1023, 0.
  - Without QOUT_RELU_EN: -2, 1023, 1023, -1024.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1,... over a full frame of ramp y[n]=n<<6.
  - Required: exactly 32 accepted beats, with lane values 4*idx+j.
  - Required: m_data stable on every stall cycle; s_ready=0 throughout.
- Back-to-back frames:
  - Stimulus: s_valid held 1 with two distinct frames; m_ready=1.
  - Required: second accept occurs exactly 1 cycle after the first frame's m_last beat.
  - Required: total 66 cycles from first accept to second frame's last beat.
- Reset mid-frame:
  - Stimulus: drive rstn=0 for one cycle after beat 10 is accepted.
  - Required: next cycle shows m_valid=0, busy=0, s_ready=1.
  - Required: a new frame then streams from beat 0 with correct values.
- Input ignored while busy:
  - Stimulus: change s_y and pulse s_valid during STREAM.
  - Required: streamed values are unaffected; no extra frame is accepted.

Source files
------------

// File: rtl/qconv2d_out_stream.sv
// qconv2d_out_stream: output stage of the combinational qconv2d array.
// Captures a whole accumulator frame in one handshake. Each word is then
// requantized (round-half-up right shift, optional ReLU, saturation to OB
// bits), and the results are streamed LANES words per beat.
// Optional feature macro: QOUT_RELU_EN (defined: ReLU before saturation,
// undefined: signed saturation only).
module qconv2d_out_stream #(
    parameter int YN    = 128,
    parameter int YB    = 21,
    parameter int OB    = 11,
    parameter int LANES = 4,
    parameter int SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [YN*YB-1:0]      s_y,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LANES*OB-1:0]   m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int BEATS  = YN / LANES;
    localparam int IW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Rounding constant 1<<(SHIFT-1), or nothing when there is no shift.
    localparam logic signed [YB:0] RND  = (SHIFT > 0) ? ((YB+1)'(1) << RND_SH) : '0;
    localparam logic signed [YB:0] OMAX = (YB+1)'((1 << (OB - 1)) - 1);
    localparam logic signed [YB:0] OMIN = ~OMAX;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q;
    logic [IW-1:0]       idx_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic                busy_q;
    logic [YN*YB-1:0]    frame_q;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [OB-1:0] requant(input logic signed [YB-1:0] y);
        logic signed [YB:0] t;
        logic signed [YB:0] r;
        t = {y[YB-1], y};
        t = t + RND;
        r = t >>> SHIFT;
`ifdef QOUT_RELU_EN
        if (r < 0) r = '0;
`else
        if (r < OMIN) r = OMIN;
`endif
        if (r > OMAX) r = OMAX;
        return r[OB-1:0];
    endfunction

    assign s_ready = rstn && (state_q == IDLE);
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;

    // Frame/stream FSM with registered handshake outputs; reset beats any handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        state_q   <= STREAM;
                        idx_q     <= '0;
                        m_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        m_last_q  <= (BEATS == 1);
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (idx_q == IW'(BEATS - 1)) begin
                            state_q   <= IDLE;
                            idx_q     <= '0;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            m_last_q <= ((idx_q + 1'b1) == IW'(BEATS - 1));
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    idx_q     <= '0;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Frame register: loaded only on an accepted frame, never cleared.
    always_ff @(posedge clk) begin
        if (s_valid && s_ready) begin
            frame_q <= s_y;
        end
    end

    // Requantize the LANES words addressed by the current beat index.
    always_comb begin
        m_data = '0;
        for (int j = 0; j < LANES; j++) begin
            m_data[j*OB +: OB] = requant(frame_q[(int'(idx_q) * LANES + j) * YB +: YB]);
        end
    end

endmodule
